// File: rtl/mips.sv
// Single-cycle 32-bit MIPS core: PC, instruction memory, register file,
// ALU, data memory and control. One instruction completes per clock.

// Instruction memory: 256 words, combinational word-addressed read.
// The load port lets the array be filled in-system; the core ties it off.
module mips_imem (
    input  logic        clock,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] instr_memory [0:255];

    // Optional program load; never enabled during normal execution.
    always_ff @(posedge clock) begin
        if (load_en) instr_memory[load_addr] <= load_data;
    end

    assign rdata = instr_memory[addr];
endmodule

// Data memory: 256 words, combinational read, synchronous write.
module mips_dmem (
    input  logic        clock,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] data_memory [0:255];

    // Store commits on the same edge that retires the sw.
    always_ff @(posedge clock) begin
        if (we) data_memory[addr] <= wdata;
    end

    assign rdata = data_memory[addr];
endmodule

// Register file: two combinational reads, one synchronous write.
// $0 reads as zero regardless of array contents and is never written.
module mips_regfile (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    // Write-back at the end of the instruction; reads see old value until then.
    always_ff @(posedge clock) begin
        if (we && (wa != 5'd0)) registers[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module mips (
    input logic clock,
    input logic reset_n
);
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE
    } alu_op_t;

    logic [31:0] pc, pc_next, pc_plus4, instruction;
    logic [31:0] read_reg_1, read_reg_2, alu_result, read_data;
    logic [31:0] simm, alu_b, write_data;
    logic        zero;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, write_reg;
    logic [15:0] imm;
    logic [25:0] target;

    logic        reg_write, mem_write, mem_to_reg, alu_src_imm, reg_dst_rd;
    logic        branch, jump;
    alu_op_t     alu_op;

    // Bits that carry no meaning in this core (shamt, byte offsets, high address bits).
    logic unused_bits;
    assign unused_bits = ^{instruction[10:6], pc[1:0], pc[31:10],
                           alu_result[1:0], alu_result[31:10]};

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign imm    = instruction[15:0];
    assign funct  = instruction[5:0];
    assign target = instruction[25:0];
    assign simm   = {{16{imm[15]}}, imm};

    mips_imem instruction_mem (
        .clock     (clock),
        .load_en   (1'b0),
        .load_addr (8'd0),
        .load_data (32'd0),
        .addr      (pc[9:2]),
        .rdata     (instruction)
    );

    mips_regfile regs (
        .clock (clock),
        .we    (reg_write && reset_n),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (write_reg),
        .wd    (write_data),
        .rd1   (read_reg_1),
        .rd2   (read_reg_2)
    );

    mips_dmem data_mem (
        .clock (clock),
        .we    (mem_write && reset_n),
        .addr  (alu_result[9:2]),
        .wdata (read_reg_2),
        .rdata (read_data)
    );

    // Main decoder; anything unrecognised falls through as a NOP.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        reg_dst_rd  = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_op      = ALU_NONE;
        case (opcode)
            6'h00: begin
                reg_dst_rd = 1'b1;
                reg_write  = 1'b1;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            6'h08: begin
                alu_op = ALU_ADD; alu_src_imm = 1'b1; reg_write = 1'b1;
            end
            6'h23: begin
                alu_op = ALU_ADD; alu_src_imm = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
            end
            6'h2B: begin
                alu_op = ALU_ADD; alu_src_imm = 1'b1; mem_write = 1'b1;
            end
            6'h04: begin
                alu_op = ALU_SUB; branch = 1'b1;
            end
            6'h02:   jump = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = alu_src_imm ? simm : read_reg_2;

    // ALU: 32-bit wrap-around arithmetic, signed set-less-than.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = read_reg_1 + alu_b;
            ALU_SUB: alu_result = read_reg_1 - alu_b;
            ALU_AND: alu_result = read_reg_1 & alu_b;
            ALU_OR:  alu_result = read_reg_1 | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(read_reg_1) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero       = (alu_result == 32'd0);
    assign write_reg  = reg_dst_rd ? rd : rt;
    assign write_data = mem_to_reg ? read_data : alu_result;

    // Next-PC selection: taken branch, jump, or sequential.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        pc_next  = pc_plus4;
        if (branch && zero)
            pc_next = pc_plus4 + {simm[29:0], 2'b00};
        else if (jump)
            pc_next = {pc_plus4[31:28], target, 2'b00};
    end

    // Program counter; reset pins it to the first instruction word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc <= 32'd0;
        else          pc <= pc_next;
    end
endmodule

// File: tb/tb_mips.sv
// Directed test of the single-cycle MIPS core using preloaded programs.
module tb_mips;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    mips dut (.clock(clock), .reset_n(reset_n));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Hold reset and wipe all storage so each scenario starts clean.
    task automatic clear_state();
        reset_n = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 256; i++) begin
            dut.instruction_mem.instr_memory[i] = 32'd0;
            dut.data_mem.data_memory[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.regs.registers[i] = 32'd0;
    endtask

    task automatic start();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        $display("step pc=%h instr=%h alu=%h", dut.pc, dut.instruction, dut.alu_result);
    endtask

    task automatic test_reset();
        clear_state();
        dut.regs.registers[1] = 32'd5;
        dut.instruction_mem.instr_memory[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", dut.pc, 32'h0); end
        vectors++; if (dut.pc_next !== 32'h4) begin errors++; $display("FAIL reset_pc_next got %h exp %h", dut.pc_next, 32'h4); end
        vectors++; if (dut.regs.registers[1] !== 32'd5) begin errors++; $display("FAIL reset_no_write got %h exp %h", dut.regs.registers[1], 32'd5); end
        start();
        step();
        vectors++; if (dut.regs.registers[1] !== 32'd9) begin errors++; $display("FAIL reset_first_instr got %h exp %h", dut.regs.registers[1], 32'd9); end
        vectors++; if (dut.pc !== 32'h4) begin errors++; $display("FAIL reset_first_pc got %h exp %h", dut.pc, 32'h4); end
    endtask

    task automatic test_rtype();
        clear_state();
        dut.regs.registers[1] = 32'd5;
        dut.regs.registers[2] = 32'd3;
        dut.regs.registers[8] = 32'h55;
        dut.regs.registers[9] = 32'hFFFF_FFFF;
        dut.instruction_mem.instr_memory[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        dut.instruction_mem.instr_memory[1] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
        dut.instruction_mem.instr_memory[2] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
        dut.instruction_mem.instr_memory[3] = enc_r(5'd1, 5'd2, 5'd6, 6'h24);
        dut.instruction_mem.instr_memory[4] = enc_r(5'd1, 5'd2, 5'd7, 6'h25);
        dut.instruction_mem.instr_memory[5] = enc_r(5'd1, 5'd2, 5'd8, 6'h2A);
        dut.instruction_mem.instr_memory[6] = enc_r(5'd9, 5'd1, 5'd10, 6'h2A);
        dut.instruction_mem.instr_memory[7] = enc_r(5'd1, 5'd1, 5'd1, 6'h20);
        dut.instruction_mem.instr_memory[8] = enc_r(5'd3, 5'd4, 5'd11, 6'h20);
        dut.instruction_mem.instr_memory[9] = enc_r(5'd2, 5'd1, 5'd12, 6'h22);
        start();
        vectors++; if (dut.alu_result !== 32'd8) begin errors++; $display("FAIL add_alu got %h exp %h", dut.alu_result, 32'd8); end
        repeat (10) step();
        vectors++; if (dut.regs.registers[3] !== 32'd8) begin errors++; $display("FAIL add got %h exp %h", dut.regs.registers[3], 32'd8); end
        vectors++; if (dut.regs.registers[4] !== 32'd2) begin errors++; $display("FAIL sub got %h exp %h", dut.regs.registers[4], 32'd2); end
        vectors++; if (dut.regs.registers[5] !== 32'd1) begin errors++; $display("FAIL slt_true got %h exp %h", dut.regs.registers[5], 32'd1); end
        vectors++; if (dut.regs.registers[6] !== 32'd1) begin errors++; $display("FAIL and got %h exp %h", dut.regs.registers[6], 32'd1); end
        vectors++; if (dut.regs.registers[7] !== 32'd7) begin errors++; $display("FAIL or got %h exp %h", dut.regs.registers[7], 32'd7); end
        vectors++; if (dut.regs.registers[8] !== 32'd0) begin errors++; $display("FAIL slt_false got %h exp %h", dut.regs.registers[8], 32'd0); end
        vectors++; if (dut.regs.registers[10] !== 32'd1) begin errors++; $display("FAIL slt_signed got %h exp %h", dut.regs.registers[10], 32'd1); end
        vectors++; if (dut.regs.registers[1] !== 32'd10) begin errors++; $display("FAIL add_self got %h exp %h", dut.regs.registers[1], 32'd10); end
        vectors++; if (dut.regs.registers[11] !== 32'd10) begin errors++; $display("FAIL raw_dep got %h exp %h", dut.regs.registers[11], 32'd10); end
        vectors++; if (dut.regs.registers[12] !== 32'hFFFF_FFF9) begin errors++; $display("FAIL sub_wrap got %h exp %h", dut.regs.registers[12], 32'hFFFF_FFF9); end
    endtask

    task automatic test_memory();
        clear_state();
        dut.data_mem.data_memory[2] = 32'hDEAD_BEEF;
        dut.data_mem.data_memory[3] = 32'h11;
        dut.regs.registers[1] = 32'd4;
        dut.instruction_mem.instr_memory[0] = enc_i(6'h23, 5'd1, 5'd6, 16'd4);
        dut.instruction_mem.instr_memory[1] = enc_i(6'h2B, 5'd0, 5'd6, 16'd0);
        dut.instruction_mem.instr_memory[2] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0404);
        dut.instruction_mem.instr_memory[3] = enc_i(6'h23, 5'd1, 5'd7, 16'hFFFC);
        start();
        vectors++; if (dut.read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_read_data got %h exp %h", dut.read_data, 32'hDEAD_BEEF); end
        step();
        vectors++; if (dut.regs.registers[6] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw got %h exp %h", dut.regs.registers[6], 32'hDEAD_BEEF); end
        step();
        vectors++; if (dut.data_mem.data_memory[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw got %h exp %h", dut.data_mem.data_memory[0], 32'hDEAD_BEEF); end
        step();
        vectors++; if (dut.data_mem.data_memory[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wrap got %h exp %h", dut.data_mem.data_memory[1], 32'hDEAD_BEEF); end
        step();
        vectors++; if (dut.regs.registers[7] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_neg_off got %h exp %h", dut.regs.registers[7], 32'hDEAD_BEEF); end
        vectors++; if (dut.data_mem.data_memory[3] !== 32'h11) begin errors++; $display("FAIL mem_untouched got %h exp %h", dut.data_mem.data_memory[3], 32'h11); end
    endtask

    task automatic test_branch();
        clear_state();
        dut.regs.registers[1] = 32'd7;
        dut.regs.registers[2] = 32'd7;
        dut.instruction_mem.instr_memory[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd3);
        dut.instruction_mem.instr_memory[8] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFE);
        start();
        repeat (4) step();
        vectors++; if (dut.pc !== 32'h10) begin errors++; $display("FAIL beq_at got %h exp %h", dut.pc, 32'h10); end
        vectors++; if (dut.zero !== 1'b1) begin errors++; $display("FAIL beq_zero got %b exp %b", dut.zero, 1'b1); end
        step();
        vectors++; if (dut.pc !== 32'h20) begin errors++; $display("FAIL beq_taken got %h exp %h", dut.pc, 32'h20); end
        vectors++; if (dut.pc_next !== 32'h1C) begin errors++; $display("FAIL beq_back_next got %h exp %h", dut.pc_next, 32'h1C); end
        step();
        vectors++; if (dut.pc !== 32'h1C) begin errors++; $display("FAIL beq_back got %h exp %h", dut.pc, 32'h1C); end

        clear_state();
        dut.regs.registers[1] = 32'd7;
        dut.regs.registers[2] = 32'd8;
        dut.instruction_mem.instr_memory[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd3);
        start();
        repeat (4) step();
        vectors++; if (dut.zero !== 1'b0) begin errors++; $display("FAIL beq_nz_zero got %b exp %b", dut.zero, 1'b0); end
        step();
        vectors++; if (dut.pc !== 32'h14) begin errors++; $display("FAIL beq_not_taken got %h exp %h", dut.pc, 32'h14); end
    endtask

    task automatic test_jump_nop();
        clear_state();
        dut.regs.registers[1] = 32'h1234;
        dut.regs.registers[2] = 32'hABCD;
        dut.regs.registers[3] = 32'h77;
        dut.instruction_mem.instr_memory[0]    = {6'h02, 26'h40};
        dut.instruction_mem.instr_memory[8'h40] = enc_i(6'h3F, 5'd1, 5'd2, 16'h0000);
        dut.instruction_mem.instr_memory[8'h41] = enc_r(5'd1, 5'd1, 5'd3, 6'h3F);
        start();
        step();
        vectors++; if (dut.pc !== 32'h100) begin errors++; $display("FAIL jump got %h exp %h", dut.pc, 32'h100); end
        step();
        vectors++; if (dut.pc !== 32'h104) begin errors++; $display("FAIL nop_op_pc got %h exp %h", dut.pc, 32'h104); end
        vectors++; if (dut.regs.registers[2] !== 32'hABCD) begin errors++; $display("FAIL nop_op_reg got %h exp %h", dut.regs.registers[2], 32'hABCD); end
        vectors++; if (dut.data_mem.data_memory[8'h8D] !== 32'd0) begin errors++; $display("FAIL nop_op_mem got %h exp %h", dut.data_mem.data_memory[8'h8D], 32'd0); end
        step();
        vectors++; if (dut.pc !== 32'h108) begin errors++; $display("FAIL nop_fn_pc got %h exp %h", dut.pc, 32'h108); end
        vectors++; if (dut.regs.registers[3] !== 32'h77) begin errors++; $display("FAIL nop_fn_reg got %h exp %h", dut.regs.registers[3], 32'h77); end
    endtask

    task automatic test_reg0_reset();
        clear_state();
        dut.regs.registers[0] = 32'h1234;
        dut.instruction_mem.instr_memory[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        dut.instruction_mem.instr_memory[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        dut.instruction_mem.instr_memory[2] = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
        start();
        step();
        vectors++; if (dut.read_reg_1 !== 32'd0) begin errors++; $display("FAIL r0_read got %h exp %h", dut.read_reg_1, 32'd0); end
        step();
        vectors++; if (dut.regs.registers[1] !== 32'd9) begin errors++; $display("FAIL r0_src got %h exp %h", dut.regs.registers[1], 32'd9); end
        step();
        vectors++; if (dut.regs.registers[2] !== 32'd18) begin errors++; $display("FAIL pre_reset got %h exp %h", dut.regs.registers[2], 32'd18); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL async_reset got %h exp %h", dut.pc, 32'h0); end
        @(posedge clock);
        #1;
        vectors++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", dut.pc, 32'h0); end
        vectors++; if (dut.regs.registers[1] !== 32'd9) begin errors++; $display("FAIL reset_keep_r1 got %h exp %h", dut.regs.registers[1], 32'd9); end
        vectors++; if (dut.regs.registers[2] !== 32'd18) begin errors++; $display("FAIL reset_keep_r2 got %h exp %h", dut.regs.registers[2], 32'd18); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_memory();
        test_branch();
        test_jump_nop();
        test_reg0_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mips.md
# mips

Single-cycle 32-bit MIPS processor core. It contains the PC, instruction memory, register file, ALU, data memory and control, and executes one instruction per clock. Program, data and register contents are preloaded by the bench through hierarchical memory loads. This is the top of the processor design and has no external data buses.

## Interface
- No parameters. Sizes are fixed: 256-word instruction memory, 256-word data memory, 32×32-bit register file.
- `clock` input 1: single system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- Ports are ordered `clock`, then `reset_n`.
- Required hierarchy and names for bench access:
  - Submodule instances `instruction_mem` (array `instr_memory[0:255]`, 32-bit), `data_mem` (array `data_memory[0:255]`, 32-bit), `regs` (array `registers[0:31]`, 32-bit).
  - Top-level nets `pc`, `instruction`, `read_reg_1`, `read_reg_2`, `alu_result`, `zero`, `read_data`, `pc_next`, all 32-bit except `zero` (1-bit).

## Operation
- PC and memory addressing:
  - `pc` is a byte address.
  - `instruction = instr_memory[pc[9:2]]`, combinational read.
- Decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0] sign-extended to 32 bits, target [25:0].
- Register file:
  - Two combinational read ports: `read_reg_1 = R[rs]`, `read_reg_2 = R[rt]`.
  - Register 0 always reads 0. Writes to register 0 are discarded.
  - One synchronous write port.
- Supported instructions (opcode/funct in hex):
  - R-type, op 00, writes rd: add 20, sub 22, and 24, or 25, slt 2A.
    - slt is a signed compare and gives 1 or 0.
  - addi 08: rt = rs + simm.
  - lw 23: rt = mem[rs+simm].
  - sw 2B: mem[rs+simm] = rt.
  - beq 04: branch if rs == rt.
  - j 02: jump.
- ALU:
  - Operands are `read_reg_1` and, for R-type/beq, `read_reg_2`, or the sign-extended imm for addi/lw/sw.
  - beq performs a subtract.
  - Arithmetic is 32-bit two's-complement wrap with no overflow trap.
  - `zero = (alu_result == 0)`.
- Data memory:
  - `read_data = data_memory[alu_result[9:2]]`, combinational.
  - Written on the rising edge when the instruction is sw.
  - Address bits [1:0] are ignored. Upper bits above [9] are ignored, so addresses wrap modulo 1 KiB.
- Next PC:
  - `pc_plus4 = pc + 4`.
  - beq with `zero` set: `pc_next = pc_plus4 + (simm << 2)`.
  - j: `pc_next = {pc_plus4[31:28], target, 2'b00}`.
  - Otherwise `pc_next = pc_plus4`.
- Undefined opcode or funct: acts as a NOP. There is no register or memory write, and `pc_next = pc + 4`.
- Register write data: `read_data` for lw, otherwise `alu_result`.

## Timing
- On the rising edge of `clock`:
  - `pc <= pc_next`.
  - The register-file write and the data-memory write for the current instruction commit on this same edge.
- All decode, ALU, memory-read and next-PC logic is combinational. Each instruction completes in exactly one cycle.
- Reset:
  - `reset_n` low forces `pc` to 0 immediately and holds it there.
  - While reset is asserted, all register-file and data-memory writes are suppressed.
  - Reset does not clear memory or register contents, so bench preloads survive reset.
- First instruction fetched after release is `instr_memory[0]`. It executes on the first rising edge with `reset_n` high.
- A read of a register written by the previous instruction returns the new value. No forwarding is needed because of the single-cycle structure.
- A read and a write of the same register within one instruction returns the old value. Example: `add $1,$1,$1` uses the pre-edge `$1`.
- PC wraps at 2^32. Instruction fetch wraps modulo 256 words.

## Test plan
- Reset: hold `reset_n` low for 2 cycles -> `pc` = 0; `pc_next` = 4 with a NOP at word 0; no register or memory changes.
- R-type: R1 = 5, R2 = 3; `add $3,$1,$2` then `sub $4,$1,$2` then `slt $5,$2,$1` -> R3 = 8, R4 = 2, R5 = 1; `and`/`or` give 1 and 7.
- Memory: `data_memory[2]` = 0xDEADBEEF, R1 = 4; `lw $6,4($1)` -> R6 = 0xDEADBEEF, `read_data` = 0xDEADBEEF; `sw $6,0($0)` -> `data_memory[0]` = 0xDEADBEEF.
- Branch: R1 = R2 = 7, `beq $1,$2,+3` at pc 0x10 -> next `pc` = 0x20, `zero` = 1. With R2 = 8 -> `pc` = 0x14, `zero` = 0.
- Jump and NOP: `j 0x40` at pc 0 -> `pc` = 0x100. An undefined opcode at 0x100 -> no state change, `pc` = 0x104.
- Register 0 and reset mid-run: `addi $0,$0,9` -> R0 still reads 0. Assert `reset_n` between edges mid-program -> `pc` = 0 at once, register values retained.
